// File: rtl/smac_ctrl_pkg.sv
// smac_ctrl_pkg: shared state type, default sizing and window helper for the stochastic MAC sequencer
package smac_ctrl_pkg;
  localparam int MAX_LOG2 = 8;
  localparam int PIPE_LAT = 2;
  localparam int CNT_W = MAX_LOG2 + 1;
  typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, DONE} state_e;
  function automatic int win_len(input logic [3:0] len);
    return 1 << len;
  endfunction
endpackage

// File: rtl/bitstream_ones_cnt.sv
// bitstream_ones_cnt: counts ones on a stochastic bitstream; also serves as a unipolar stream-to-binary converter
module bitstream_ones_cnt
  import smac_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  // clear has priority; otherwise add the bit whenever enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= clr_i ? '0 : count_q + W'(en_i & bit_i);
  assign count_o = count_q;
endmodule

// File: rtl/smac_stream_ctrl.sv
// smac_stream_ctrl: job sequencer driving MAC load, Sobol RNG control and the ones-count result port
module smac_stream_ctrl #(
  parameter int MAX_LOG2 = smac_ctrl_pkg::MAX_LOG2,
  parameter int PIPE_LAT = smac_ctrl_pkg::PIPE_LAT,
  parameter int CNT_W = MAX_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             startReady,
  input  logic [3:0]       lenLog2,
  input  logic             abort,
  output logic             loadA,
  output logic             loadB,
  output logic             rngClr,
  output logic             rngEn,
  input  logic             macBit,
  output logic [CNT_W-1:0] result,
  output logic             resultValid,
  input  logic             resultReady,
  output logic             busy
);
  import smac_ctrl_pkg::*;
  state_e           state_q, state_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] win_q, ones_cnt, result_q;
  logic             ld_q, en_q, vld_q, busy_q, rdy_q;
  logic             fill_last, win_last;
  assign len_d = (lenLog2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : lenLog2;
  assign fill_last = win_q == CNT_W'(PIPE_LAT - 1);
  assign win_last = win_q == CNT_W'(win_len(len_q) - 1);
  // next-state decode; abort beats everything, including a same-cycle start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (start && !abort) ? LOAD : IDLE;
      LOAD: state_d = abort ? IDLE : (PIPE_LAT == 0) ? RUN : FILL;
      FILL: state_d = abort ? IDLE : fill_last ? RUN : FILL;
      RUN:  state_d = abort ? IDLE : win_last ? DONE : RUN;
      DONE: state_d = (abort || resultReady) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register with outputs decoded from the next state so they are registered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q <= 1'b0;
      en_q <= 1'b0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ld_q <= state_d == LOAD;
      en_q <= state_d inside {FILL, RUN};
      vld_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
      rdy_q <= state_d == IDLE;
    end
  // window length latch, shared fill/window cycle counter, and result capture including the final bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_q <= '0;
      win_q <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == LOAD) len_q <= len_d;
      win_q <= (state_q == LOAD || (state_q == FILL && fill_last)) ? '0 :
               (state_q inside {FILL, RUN}) ? win_q + 1'b1 : win_q;
      if (state_q == RUN && state_d == DONE) result_q <= ones_cnt + CNT_W'(macBit);
    end
  bitstream_ones_cnt #(.W(CNT_W)) u_ones (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == LOAD),
    .en_i   (state_q == RUN),
    .bit_i  (macBit),
    .count_o(ones_cnt)
  );
  assign loadA = ld_q;
  assign loadB = ld_q;
  assign rngClr = ld_q;
  assign rngEn = en_q;
  assign resultValid = vld_q;
  assign busy = busy_q;
  assign startReady = rdy_q;
  assign result = result_q;
endmodule

// File: tb/tb_smac_stream_ctrl.sv
// tb_smac_stream_ctrl: table-driven job vectors plus abort, reset and backpressure sequences
module tb_smac_stream_ctrl;
  localparam int P = 2;
  localparam int CW = 9;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          macBit = 1'b0;
  logic          resultReady = 1'b0;
  logic [3:0]    lenLog2 = 4'd0;
  logic          startReady, loadA, loadB, rngClr, rngEn, resultValid, busy;
  logic [CW-1:0] result;
  int            n_cmp = 0;
  int            n_bad = 0;
  typedef struct {
    logic [3:0] len;
    int         mode;
    int         exp;
    int         hold;
  } vec_t;
  vec_t v[7];

  smac_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .startReady (startReady),
    .lenLog2    (lenLog2),
    .abort      (abort),
    .loadA      (loadA),
    .loadB      (loadB),
    .rngClr     (rngClr),
    .rngEn      (rngEn),
    .macBit     (macBit),
    .result     (result),
    .resultValid(resultValid),
    .resultReady(resultReady),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {loadA, loadB, rngClr, rngEn, resultValid, busy, startReady};
  endfunction

  function automatic logic pat(input int mode, input int r, input int w);
    case (mode)
      0: return 1'b1;
      1: return (r % 2) == 0;
      3: return r < 5;
      4: return r == w - 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [3:0] l, input int mode, input int exp, input int hold);
    int w;
    int last;
    w = 1 << ((l > 4'd8) ? 8 : int'(l));
    last = 2 + P + w;
    chk("idle_before", ctl(), 7'b0000001);
    start = 1'b1;
    lenLog2 = l;
    for (int c = 1; c <= last; c++) begin
      step();
      start = 1'b0;
      if (c == 3) lenLog2 = ~l;
      macBit = (c >= 2 + P && c < 2 + P + w) ? pat(mode, c - 2 - P, w) : 1'b0;
      if (c == 1) chk("load_ctl", ctl(), 7'b1110010);
      else if (c < last) chk("fill_run_ctl", ctl(), 7'b0001010);
      else chk("done_ctl", ctl(), 7'b0000110);
    end
    chk("result", result, exp);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      step();
      chk("bp_result", result, exp);
      chk("bp_ctl", ctl(), 7'b0000110);
    end
    start = 1'b0;
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    chk("idle_after_ready", ctl(), 7'b0000001);
    step();
    chk("no_queued_start", ctl(), 7'b0000001);
  endtask

  initial begin
    v[0] = '{4'd8, 0, 256, 5};
    v[1] = '{4'd4, 1, 8, 0};
    v[2] = '{4'd0, 0, 1, 0};
    v[3] = '{4'd15, 2, 0, 1};
    v[4] = '{4'd3, 3, 5, 2};
    v[5] = '{4'd2, 4, 1, 0};
    v[6] = '{4'd1, 1, 1, 0};
    repeat (3) step();
    chk("reset_ctl", ctl(), 7'b0000001);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) run_job(v[i].len, v[i].mode, v[i].exp, v[i].hold);
    run_job(4'd8, 0, 256, 0);
    start = 1'b1;
    lenLog2 = 4'd8;
    for (int c = 1; c <= 2 + P + 50; c++) begin
      step();
      start = 1'b0;
      macBit = 1'b1;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", ctl(), 7'b0000001);
    chk("abort_keeps_result", result, 256);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("abort_no_valid", resultValid, 0);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_rejected", ctl(), 7'b0000001);
    start = 1'b1;
    lenLog2 = 4'd0;
    for (int c = 1; c <= 3 + P; c++) begin
      step();
      start = 1'b0;
    end
    chk("done_before_abort", ctl(), 7'b0000110);
    chk("done_result", result, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_done", ctl(), 7'b0000001);
    chk("abort_in_done_result", result, 1);
    start = 1'b1;
    lenLog2 = 4'd8;
    for (int c = 1; c <= 30; c++) begin
      step();
      start = 1'b0;
    end
    chk("midrun_busy", ctl(), 7'b0001010);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_ctl", ctl(), 7'b0000001);
    chk("midrun_reset_result", result, 0);
    step();
    rst_n = 1'b1;
    macBit = 1'b0;
    step();
    run_job(4'd4, 1, 8, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/smac_stream_ctrl.md
Name: smac_stream_ctrl

Overview:
- Sequencer for the 16-lane unipolar stochastic MAC (Sobol RNG pair, gain multipliers, OR adder).
- Per job:
  - pulses operand load;
  - restarts and enables the Sobol RNGs;
  - skips the MAC pipeline fill;
  - counts ones on the MAC output bit over a 2^len-cycle window.
- Returns the binary count through a valid/ready result port. It is the only block that drives the MAC load and RNG control lines.

Parameters:
- MAX_LOG2, 8, maximum log2 stream length; matches 8-bit Sobol period.
- PIPE_LAT, 2, cycles from first enabled RNG value to the corresponding MAC output bit.
- CNT_W, MAX_LOG2+1, result width; holds 0..2^MAX_LOG2 inclusive.

Ports:
- clk, in, 1, clock; single clock domain.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, job request; accepted when start && startReady.
- startReady, out, 1, high only in IDLE.
- lenLog2, in, 4, log2 window length; sampled on start acceptance.
- abort, in, 1, synchronous cancel of the current job.
- loadA, out, 1, operand-A load strobe to MAC.
- loadB, out, 1, operand-B load strobe to MAC.
- rngClr, out, 1, synchronous restart of both Sobol RNGs to index 0.
- rngEn, out, 1, RNG advance enable.
- macBit, in, 1, MAC stochastic output bit (oC).
- result, out, CNT_W, ones count of the last completed window.
- resultValid, out, 1, result available.
- resultReady, in, 1, result consumer ready.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; all counters 0;
  - loadA/loadB/rngClr/rngEn/resultValid/busy = 0; startReady = 1; result = 0.
- States: IDLE, LOAD, FILL, RUN, DONE. Registered outputs.
- IDLE:
  - on start acceptance, latch len = min(lenLog2, MAX_LOG2), go to LOAD next cycle;
  - lenLog2 = 0 is legal and gives a 1-cycle window.
- LOAD (exactly 1 cycle):
  - loadA = loadB = rngClr = 1, rngEn = 0;
  - clear onesCnt and winCnt; go to FILL.
- FILL (exactly PIPE_LAT cycles):
  - rngEn = 1; macBit ignored; go to RUN.
  - If PIPE_LAT = 0, skip FILL and go LOAD -> RUN.
- RUN (exactly 2^len cycles):
  - rngEn = 1; onesCnt += macBit each cycle; winCnt increments.
  - On the last cycle, including that cycle's macBit, go to DONE.
  - result register loads the final onesCnt on DONE entry.
- DONE:
  - rngEn = 0; resultValid = 1;
  - result is stable while resultValid && !resultReady;
  - on resultValid && resultReady, go to IDLE; resultValid drops the next cycle.
- Timing: start accepted at edge T gives
  - LOAD at T+1;
  - RUN from T+2+PIPE_LAT;
  - resultValid at T+2+PIPE_LAT+2^len.
- start while not IDLE: ignored (startReady = 0); not queued.
- abort:
  - in LOAD, FILL or RUN: go to IDLE next cycle, no result produced, previous result value retained;
  - in DONE: drops resultValid and goes to IDLE;
  - in IDLE: no effect;
  - abort and start together in IDLE: abort wins, start not accepted.
- Count range: all-ones window gives result = 2^len; CNT_W bits; no saturation needed.
- rst_n asserted mid-job: immediate return to reset values; no partial result.
- lenLog2 changes after acceptance: no effect until the next job.

Decomposition:
- Package smac_ctrl_pkg holds:
  - state enum type (IDLE, LOAD, FILL, RUN, DONE);
  - MAX_LOG2, PIPE_LAT and CNT_W defaults;
  - a function returning window length from len.
- One sub-module, bitstream_ones_cnt:
  - CNT_W-bit ones counter with clr, en, bit inputs and count output;
  - also reusable for the unipolar stochastic-to-binary converter.

Test Plan:
- Timing: lenLog2 = 8, macBit held 1, start pulse at cycle 10 -> loadA/loadB/rngClr high at cycle 11 only; rngEn high for cycles 12..269; resultValid at 270 with result = 256.
- Alternating pattern: lenLog2 = 4, macBit alternating 1,0 from the first RUN cycle -> result = 8 after 16 RUN cycles; lenLog2 = 0 with macBit = 1 -> result = 1.
- Clamping: lenLog2 = 15 -> window 256 cycles; all-zero macBit -> result = 0.
- Backpressure: resultReady low for 5 cycles after resultValid -> result and resultValid held constant; start pulses ignored with startReady = 0; IDLE entered one cycle after ready.
- Abort: abort at RUN cycle 50 -> IDLE next cycle, resultValid never asserts, result keeps prior value 256; then start with abort in the same cycle -> not accepted.
- Reset mid-RUN: rst_n low mid-RUN -> all outputs at reset values immediately; a new job after release completes normally with the correct count.
